// File: rtl/demux16_stream_if.sv
// demux16_stream_if: one input stream with select, NUM_OUT output streams and drop status.
// master drives the input word and consumer readies; slave is the demultiplexer.
interface demux16_stream_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic [SEL_W-1:0]         in_sel;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [NUM_OUT*WIDTH-1:0] out_data;
    logic                     drop_pulse;
    logic [7:0]               drop_count;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, drop_pulse, drop_count
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, drop_pulse, drop_count
    );
endinterface

// File: rtl/demux16_stream.sv
// demux16_stream: registered 1-to-NUM_OUT stream demultiplexer with a one-word holding
// register per channel; words with an out-of-range select are discarded and counted.
module demux16_stream #(
    parameter int WIDTH   = 16,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input logic             clk,
    input logic             rst,
    demux16_stream_if.slave bus
);
    logic [NUM_OUT-1:0]       valid_q, valid_d, hit, blocked;
    logic [NUM_OUT*WIDTH-1:0] data_q, data_d;
    logic                     drop_q, drop_d, ready, accept;
    logic [7:0]               cnt_q, cnt_d;

    // An out-of-range select hits no channel, so it is never blocked and falls through to the drop path.
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
        assign hit[k]                   = bus.in_sel == SEL_W'(k);
        assign blocked[k]               = hit[k] & valid_q[k] & ~bus.out_ready[k];
        assign valid_d[k]               = (accept & hit[k]) | (valid_q[k] & ~bus.out_ready[k]);
        assign data_d[k*WIDTH +: WIDTH] = accept & hit[k] ? bus.in_data : data_q[k*WIDTH +: WIDTH];
    end

    assign ready  = ~rst & ~|blocked;
    assign accept = bus.in_valid & ready;
    assign drop_d = accept & ~|hit;
    assign cnt_d  = cnt_q + {7'd0, drop_d & ~&cnt_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;
    assign bus.drop_pulse = drop_q;
    assign bus.drop_count = cnt_q;
endmodule
